// File: rtl/dphy_pkg.sv
// Shared types and constants for the D-PHY high-speed burst sequencer.
package dphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP01,
        ST_PREPARE,
        ST_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } state_t;

    localparam logic [7:0] C_SYNC_BYTE = 8'hB8;

    // LP line codes, packed as {p, n}
    localparam logic [1:0] C_LP11 = 2'b11;
    localparam logic [1:0] C_LP01 = 2'b01;
    localparam logic [1:0] C_LP00 = 2'b00;

    // A timed state lasting n cycles loads n-1 and leaves when the counter reads zero
    function automatic logic [7:0] f_tc_load(input int n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/dphy_timer.sv
// Loadable 8-bit down-counter with a zero flag; parks at zero once expired.
module dphy_timer (
    input  logic       clk_word,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       is_zero
);

    logic [7:0] count_q;

    // load on state entry, otherwise count down until zero
    always_ff @(posedge clk_word or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != 8'd0) begin
            count_q <= count_q - 8'd1;
        end
    end

    assign is_zero = (count_q == 8'd0);

endmodule

// File: rtl/dphy_hs_sequencer.sv
// Sequences one MIPI D-PHY high-speed burst across all data lanes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | LP-11, waiting for req_i && enable_i
// LP01    | LP-01 request, g_t_lpx cycles
// PREPARE | LP-00 with HS driver already enabled, data 0x00
// ZERO    | HS-zero, LP drivers released
// SYNC    | one cycle of the sync byte on every lane
// DATA    | payload streaming; ends on d_last_i or on underflow
// TRAIL   | each lane drives the inverse of its last transmitted bit 7
// EXIT    | LP-11 for g_t_hs_exit cycles; chains into LP01 if still requested
module dphy_hs_sequencer
    import dphy_pkg::*;
#(
    parameter int g_lanes        = 3,
    parameter int g_t_lpx        = 4,
    parameter int g_t_hs_prepare = 2,
    parameter int g_t_hs_zero    = 6,
    parameter int g_t_hs_trail   = 4,
    parameter int g_t_hs_exit    = 6
) (
    input  logic                   clk_word_i,
    input  logic                   rst_n_a_i,
    input  logic                   enable_i,
    input  logic                   req_i,
    input  logic [8*g_lanes-1:0]   d_i,
    input  logic                   d_valid_i,
    input  logic                   d_last_i,
    output logic                   d_ready_o,
    output logic [8*g_lanes-1:0]   serdes_data_o,
    output logic [g_lanes-1:0]     serdes_oe_o,
    output logic [g_lanes-1:0]     lp_p_o,
    output logic [g_lanes-1:0]     lp_n_o,
    output logic [g_lanes-1:0]     lp_oe_o,
    output logic                   busy_o,
    output logic                   underflow_o
);

    // the 8-bit timer holds at most 255, i.e. 256 cycles
    if (g_lanes < 1 ||
        g_t_lpx < 1 || g_t_lpx > 256 ||
        g_t_hs_prepare < 1 || g_t_hs_prepare > 256 ||
        g_t_hs_zero < 1 || g_t_hs_zero > 256 ||
        g_t_hs_trail < 1 || g_t_hs_trail > 256 ||
        g_t_hs_exit < 1 || g_t_hs_exit > 256) begin : g_param_check
        $error("dphy_hs_sequencer: timing parameters must be in 1..256");
    end

    state_t                 state_q, state_d;
    logic                   tmr_load, tmr_zero;
    logic [7:0]             tmr_val;
    logic                   accept;
    logic                   underflow_d;
    logic [g_lanes-1:0]     trail_q, trail_d;
    logic [8*g_lanes-1:0]   trail_bytes;
    logic [8*g_lanes-1:0]   data_d;
    logic [1:0]             lp_code;
    logic                   lp_oe_d, serdes_oe_d;

    dphy_timer u_timer (
        .clk_word (clk_word_i),
        .rst_n    (rst_n_a_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .is_zero  (tmr_zero)
    );

    // state register
    always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state, payload handshake and timer reload
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        underflow_d = 1'b0;
        case (state_q)
            ST_IDLE:    if (req_i && enable_i) state_d = ST_LP01;
            ST_LP01:    if (tmr_zero) state_d = ST_PREPARE;
            ST_PREPARE: if (tmr_zero) state_d = ST_ZERO;
            ST_ZERO:    if (tmr_zero) state_d = ST_SYNC;
            ST_SYNC:    state_d = ST_DATA;
            ST_DATA: begin
                if (d_valid_i) begin
                    accept = 1'b1;
                    if (d_last_i) state_d = ST_TRAIL;
                end else begin
                    underflow_d = 1'b1;
                    state_d     = ST_TRAIL;
                end
            end
            ST_TRAIL:   if (tmr_zero) state_d = ST_EXIT;
            // going straight to LP01 keeps back-to-back bursts exactly g_t_hs_exit apart
            ST_EXIT:    if (tmr_zero) state_d = (req_i && enable_i) ? ST_LP01 : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        tmr_load = (state_d != state_q);
        case (state_d)
            ST_LP01:    tmr_val = f_tc_load(g_t_lpx);
            ST_PREPARE: tmr_val = f_tc_load(g_t_hs_prepare);
            ST_ZERO:    tmr_val = f_tc_load(g_t_hs_zero);
            ST_TRAIL:   tmr_val = f_tc_load(g_t_hs_trail);
            ST_EXIT:    tmr_val = f_tc_load(g_t_hs_exit);
            default:    tmr_val = 8'd0;
        endcase
    end

    // per-lane trail pattern from the last transmitted bit 7
    always_comb begin
        trail_bytes = '0;
        for (int l = 0; l < g_lanes; l++) begin
            trail_bytes[l*8 +: 8] = {8{~trail_q[l]}};
        end
    end

    // output values for the cycle following this edge, keyed on the next state
    always_comb begin
        trail_d     = trail_q;
        data_d      = '0;
        lp_code     = C_LP00;
        lp_oe_d     = 1'b0;
        serdes_oe_d = 1'b0;
        if (state_d == ST_SYNC) begin
            trail_d = {g_lanes{C_SYNC_BYTE[7]}};
        end
        if (accept) begin
            for (int l = 0; l < g_lanes; l++) begin
                trail_d[l] = d_i[l*8 + 7];
            end
        end
        case (state_d)
            ST_IDLE, ST_EXIT: begin
                lp_code = C_LP11;
                lp_oe_d = 1'b1;
            end
            ST_LP01: begin
                lp_code = C_LP01;
                lp_oe_d = 1'b1;
            end
            ST_PREPARE: begin
                lp_oe_d     = 1'b1;
                serdes_oe_d = 1'b1;
            end
            ST_ZERO: serdes_oe_d = 1'b1;
            ST_SYNC: begin
                serdes_oe_d = 1'b1;
                data_d      = {g_lanes{C_SYNC_BYTE}};
            end
            // without a new word the serializers keep the last one
            ST_DATA: begin
                serdes_oe_d = 1'b1;
                data_d      = accept ? d_i : serdes_data_o;
            end
            // the final payload word goes out before the trail pattern
            ST_TRAIL: begin
                serdes_oe_d = 1'b1;
                data_d      = accept ? d_i : trail_bytes;
            end
            default: ;
        endcase
    end

    // registered outputs
    always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            serdes_data_o <= '0;
            serdes_oe_o   <= '0;
            lp_p_o        <= '1;
            lp_n_o        <= '1;
            lp_oe_o       <= '1;
            d_ready_o     <= 1'b0;
            busy_o        <= 1'b0;
            underflow_o   <= 1'b0;
            trail_q       <= '0;
        end else begin
            serdes_data_o <= data_d;
            serdes_oe_o   <= {g_lanes{serdes_oe_d}};
            lp_p_o        <= {g_lanes{lp_code[1]}};
            lp_n_o        <= {g_lanes{lp_code[0]}};
            lp_oe_o       <= {g_lanes{lp_oe_d}};
            d_ready_o     <= (state_d == ST_DATA);
            busy_o        <= (state_d != ST_IDLE);
            underflow_o   <= underflow_d;
            trail_q       <= trail_d;
        end
    end

endmodule

// File: tb/tb_dphy_hs_sequencer.sv
// Directed and randomized bursts checked cycle by cycle against a segment-based model.
module tb_dphy_hs_sequencer;

    localparam int L       = 3;
    localparam int T_LPX   = 4;
    localparam int T_PREP  = 2;
    localparam int T_ZERO  = 6;
    localparam int T_TRAIL = 4;
    localparam int T_EXIT  = 6;

    typedef struct packed {
        logic [L-1:0]   lp_p;
        logic [L-1:0]   lp_n;
        logic [L-1:0]   lp_oe;
        logic [L-1:0]   soe;
        logic [8*L-1:0] data;
        logic           rdy;
        logic           busy;
        logic           uf;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable, req, d_valid, d_last;
    logic [8*L-1:0] d;
    logic           d_ready, busy, underflow;
    logic [8*L-1:0] serdes_data;
    logic [L-1:0]   serdes_oe, lp_p, lp_n, lp_oe;

    int n_vec = 0;
    int n_err = 0;
    logic [8*L-1:0] payload[$];
    logic [8*L-1:0] sync_all;

    always #5 clk = ~clk;

    dphy_hs_sequencer #(
        .g_lanes(L), .g_t_lpx(T_LPX), .g_t_hs_prepare(T_PREP), .g_t_hs_zero(T_ZERO),
        .g_t_hs_trail(T_TRAIL), .g_t_hs_exit(T_EXIT)
    ) dut (
        .clk_word_i    (clk),
        .rst_n_a_i     (rst_n),
        .enable_i      (enable),
        .req_i         (req),
        .d_i           (d),
        .d_valid_i     (d_valid),
        .d_last_i      (d_last),
        .d_ready_o     (d_ready),
        .serdes_data_o (serdes_data),
        .serdes_oe_o   (serdes_oe),
        .lp_p_o        (lp_p),
        .lp_n_o        (lp_n),
        .lp_oe_o       (lp_oe),
        .busy_o        (busy),
        .underflow_o   (underflow)
    );

    // LP line levels only matter while the LP drivers are on
    function automatic obs_t sample();
        obs_t o;
        o.lp_p  = lp_p & lp_oe;
        o.lp_n  = lp_n & lp_oe;
        o.lp_oe = lp_oe;
        o.soe   = serdes_oe;
        o.data  = serdes_data;
        o.rdy   = d_ready;
        o.busy  = busy;
        o.uf    = underflow;
        return o;
    endfunction

    function automatic obs_t mk(input logic p, input logic n, input logic oe, input logic soe,
                                input logic [8*L-1:0] data, input logic rdy, input logic bsy,
                                input logic uf);
        obs_t o;
        o.lp_p  = {L{p & oe}};
        o.lp_n  = {L{n & oe}};
        o.lp_oe = {L{oe}};
        o.soe   = {L{soe}};
        o.data  = data;
        o.rdy   = rdy;
        o.busy  = bsy;
        o.uf    = uf;
        return o;
    endfunction

    function automatic logic [8*L-1:0] trail_of(input logic [8*L-1:0] w);
        logic [8*L-1:0] r;
        r = '0;
        for (int l = 0; l < L; l++) r[l*8 +: 8] = {8{~w[l*8+7]}};
        return r;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t exp_o);
        obs_t got;
        got = sample();
        n_vec++;
        assert (got === exp_o) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp_o);
        end
    endtask

    // Entered at a negedge in IDLE (or in the last EXIT cycle of a chained burst).
    // uf_after < 0: all n_words sent with d_last on the final one;
    // otherwise d_valid drops after uf_after words.
    task automatic run_burst(input int n_words, input int uf_after, input bit hold_req,
                             input int en_drop_at, input string tag);
        int m, t_data, t_trail, t_exit, len, j;
        obs_t e;
        logic [8*L-1:0] line_w;
        m       = (uf_after < 0) ? n_words : uf_after + 1;
        t_data  = T_LPX + T_PREP + T_ZERO + 1;
        t_trail = t_data + m;
        t_exit  = t_trail + T_TRAIL;
        len     = t_exit + T_EXIT;
        line_w  = sync_all;
        req     = 1'b1;
        enable  = 1'b1;
        d_valid = 1'b0;
        d_last  = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c < T_LPX)                e = mk(0, 1, 1, 0, '0, 0, 1, 0);
            else if (c < T_LPX + T_PREP)  e = mk(0, 0, 1, 1, '0, 0, 1, 0);
            else if (c < t_data - 1)      e = mk(0, 0, 0, 1, '0, 0, 1, 0);
            else if (c == t_data - 1)     e = mk(0, 0, 0, 1, sync_all, 0, 1, 0);
            else if (c < t_trail)         e = mk(0, 0, 0, 1, line_w, 1, 1, 0);
            else if (c < t_exit) begin
                if (c == t_trail && uf_after < 0) e = mk(0, 0, 0, 1, line_w, 0, 1, 0);
                else e = mk(0, 0, 0, 1, trail_of(line_w), 0, 1, (c == t_trail && uf_after >= 0));
            end else                      e = mk(1, 1, 1, 0, '0, 0, 1, 0);
            check(tag, c, e);
            d_valid = 1'b0;
            d_last  = 1'(($urandom() >> 3) & 1);
            d       = (8*L)'($urandom());
            if (c >= t_data && c < t_trail) begin
                j = c - t_data;
                if (!(uf_after >= 0 && j == uf_after)) begin
                    d_valid = 1'b1;
                    d       = payload[j];
                    d_last  = (uf_after < 0 && j == n_words - 1);
                    line_w  = payload[j];
                end else begin
                    d_last = 1'b0;
                end
            end
            if (en_drop_at >= 0 && c >= en_drop_at) enable = 1'b0;
            req = hold_req;
        end
        if (!(hold_req && enable)) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check({tag, "_idle"}, len + k, mk(1, 1, 1, 0, '0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        int n, uf;
        sync_all = {L{8'hB8}};
        rst_n   = 1'b0;
        enable  = 1'b0;
        req     = 1'b0;
        d_valid = 1'b0;
        d_last  = 1'b0;
        d       = '0;

        // reset values, while held and after release
        repeat (2) @(negedge clk);
        check("reset_held", 0, mk(1, 1, 1, 0, '0, 0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rel", 0, mk(1, 1, 1, 0, '0, 0, 0, 0));
        enable = 1'b1;
        @(negedge clk);
        check("idle_no_req", 0, mk(1, 1, 1, 0, '0, 0, 0, 0));

        // single word, lanes 0x55 / 0x0F / 0x80
        payload.delete();
        payload.push_back(24'h800F55);
        run_burst(1, -1, 1'b0, -1, "single");

        // 16-word burst with valid held high
        payload.delete();
        for (int i = 0; i < 16; i++) payload.push_back((8*L)'($urandom()));
        run_burst(16, -1, 1'b0, -1, "burst16");

        // valid dropped after word 3 of 8
        payload.delete();
        for (int i = 0; i < 8; i++) payload.push_back((8*L)'($urandom()));
        run_burst(8, 3, 1'b0, -1, "underflow3");

        // req held: back-to-back bursts, then enable dropped mid-burst
        payload.delete();
        for (int i = 0; i < 4; i++) payload.push_back((8*L)'($urandom()));
        run_burst(4, -1, 1'b1, -1, "b2b_a");
        payload.delete();
        for (int i = 0; i < 3; i++) payload.push_back((8*L)'($urandom()));
        run_burst(3, -1, 1'b1, 5, "b2b_b");
        req    = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // reset pulsed during ZERO
        req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = 1'b0;
        end
        check("pre_rst_zero", 7, mk(0, 0, 0, 1, '0, 0, 1, 0));
        #2 rst_n = 1'b0;
        #1 check("rst_in_zero", 0, mk(1, 1, 1, 0, '0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 0, mk(1, 1, 1, 0, '0, 0, 0, 0));
        payload.delete();
        for (int i = 0; i < 5; i++) payload.push_back((8*L)'($urandom()));
        run_burst(5, -1, 1'b0, -1, "post_rst");

        // randomized bursts, some truncated by underflow (including in the first DATA cycle)
        for (int b = 0; b < 8; b++) begin
            n  = $urandom_range(1, 10);
            uf = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            payload.delete();
            for (int i = 0; i < n; i++) payload.push_back((8*L)'($urandom()));
            run_burst(n, uf, 1'b0, -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
